// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting one writer and one reader access to a single
// memory port; all outputs registered, read data returned after RD_LATENCY.
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 29,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req_l,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [DATA_WIDTH-1:0] wr_req_data,
  output logic                  wr_ack_l,
  input  logic                  rd_req_l,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  output logic                  rd_ack_l,
  output logic [DATA_WIDTH-1:0] rd_resp_data,
  output logic                  mem_wr_en_l,
  output logic                  mem_rd_en_l,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, READ_WAIT} state_t;
  typedef enum logic {GRANT_WR, GRANT_RD} grant_t;

  state_t                state, state_d;
  grant_t                last_grant, last_grant_d;
  logic [3:0]            cnt, cnt_d;
  logic                  grant_wr, grant_rd;

  logic                  wr_ack_d, rd_ack_d, wr_en_d, rd_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d, rd_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_d, rd_resp_d;

  // Output registers are loaded from the next-state decode so that each
  // strobe/ack is aligned with the state it belongs to.
  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    cnt_d        = cnt;
    wr_ack_d     = 1'b1;
    rd_ack_d     = 1'b1;
    wr_en_d      = 1'b1;
    rd_en_d      = 1'b1;
    wr_addr_d    = mem_wr_addr;
    rd_addr_d    = mem_rd_addr;
    wr_data_d    = mem_wr_data;
    rd_resp_d    = rd_resp_data;
    grant_wr     = 1'b0;
    grant_rd     = 1'b0;

    case (state)
      IDLE: begin
        grant_wr = !wr_req_l && (rd_req_l || last_grant == GRANT_RD);
        grant_rd = !rd_req_l && !grant_wr;
        if (grant_wr) begin
          state_d      = WRITE;
          last_grant_d = GRANT_WR;
          wr_en_d      = 1'b0;
          wr_ack_d     = 1'b0;
          wr_addr_d    = wr_req_addr;
          wr_data_d    = wr_req_data;
        end else if (grant_rd) begin
          state_d      = READ;
          last_grant_d = GRANT_RD;
          rd_en_d      = 1'b0;
          rd_addr_d    = rd_req_addr;
        end
      end
      WRITE: state_d = IDLE;
      READ: begin
        state_d = READ_WAIT;
        cnt_d   = 4'(RD_LATENCY);
      end
      READ_WAIT: begin
        // The cycle in which the count has just reached zero carries the ack;
        // its closing edge returns to IDLE, so a held request is not re-granted.
        if (cnt == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt - 4'd1;
          if (cnt == 4'd1) begin
            rd_ack_d  = 1'b0;
            rd_resp_d = mem_rd_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      last_grant   <= GRANT_RD;
      cnt          <= '0;
      wr_ack_l     <= 1'b1;
      rd_ack_l     <= 1'b1;
      mem_wr_en_l  <= 1'b1;
      mem_rd_en_l  <= 1'b1;
      mem_wr_addr  <= '0;
      mem_rd_addr  <= '0;
      mem_wr_data  <= '0;
      rd_resp_data <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      last_grant   <= last_grant_d;
      cnt          <= cnt_d;
      wr_ack_l     <= wr_ack_d;
      rd_ack_l     <= rd_ack_d;
      mem_wr_en_l  <= wr_en_d;
      mem_rd_en_l  <= rd_en_d;
      mem_wr_addr  <= wr_addr_d;
      mem_rd_addr  <= rd_addr_d;
      mem_wr_data  <= wr_data_d;
      rd_resp_data <= rd_resp_d;
      busy         <= (state_d != IDLE);
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, memory word width.
REQ-002 Parameter ADDR_WIDTH, default 29, memory address width.
REQ-003 Parameter RD_LATENCY, default 2, cycles from mem_rd_en_l low until mem_rd_data valid; legal range 1-15.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 wr_req_l  in  1  writer request, active-low.
REQ-008 wr_req_addr  in  ADDR_WIDTH  writer target address.
REQ-009 wr_req_data  in  DATA_WIDTH  writer data.
REQ-010 wr_ack_l  out  1  write-issued pulse, active-low.
REQ-011 rd_req_l  in  1  reader request, active-low.
REQ-012 rd_req_addr  in  ADDR_WIDTH  reader source address.
REQ-013 rd_ack_l  out  1  read-data-valid pulse, active-low.
REQ-014 rd_resp_data  out  DATA_WIDTH  returned read data.
REQ-015 mem_wr_en_l, mem_rd_en_l  out  1 each  memory strobes, active-low.
REQ-016 mem_wr_addr, mem_rd_addr  out  ADDR_WIDTH  memory addresses.
REQ-017 mem_wr_data  out  DATA_WIDTH; mem_rd_data  in  DATA_WIDTH.
REQ-018 busy  out  1  high whenever state is not IDLE.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 States SHALL be IDLE, WRITE, READ, READ_WAIT; at most one memory strobe low in any cycle.
REQ-021 IDLE: only wr_req_l low -> latch wr_req_addr/wr_req_data, go WRITE; only rd_req_l low -> latch rd_req_addr, go READ; neither -> stay IDLE.
REQ-022 IDLE, both low: grant the requester not served last (round-robin via last_grant register); last_grant updates on every grant.
REQ-023 WRITE (exactly one cycle): mem_wr_en_l=0, mem_wr_addr/mem_wr_data = latched values, wr_ack_l=0; next state IDLE.
REQ-024 READ (exactly one cycle): mem_rd_en_l=0, mem_rd_addr = latched address; load latency counter with RD_LATENCY; next state READ_WAIT.
REQ-025 READ_WAIT: decrement counter each cycle; on count reaching 0 capture mem_rd_data into rd_resp_data and drive rd_ack_l=0 for exactly one cycle, same cycle returning to IDLE.
REQ-026 Read ack SHALL therefore appear RD_LATENCY+1 edges after the READ cycle; write ack coincides with the WRITE cycle.
REQ-027 Requester handshake: hold req low and addr/data stable until ack sampled low, then raise req at that same edge; minimum turnaround one request per 2 cycles (write), RD_LATENCY+3 (read).
REQ-028 Request withdrawn after grant SHALL NOT abort the transaction; ack still issued.
REQ-029 Request inputs SHALL be ignored outside IDLE; no queuing.
REQ-030 rd_resp_data SHALL hold its value until the next read capture.
REQ-031 mem_wr_addr/mem_rd_addr/mem_wr_data SHALL hold last driven values when strobes deasserted.
REQ-032 Same address on both requests SHALL NOT get special handling; ordering follows round-robin.

Reset
REQ-033 reset low at a rising edge: state IDLE, last_grant = READ (first contention goes to writer), latency counter 0.
REQ-034 Reset values: wr_ack_l=1, rd_ack_l=1, mem_wr_en_l=1, mem_rd_en_l=1, busy=0, all address/data outputs 0.
REQ-035 Reset mid-READ_WAIT SHALL drop the read with no rd_ack_l pulse; reset overrides all transitions.

Verification
REQ-036 Single write: wr_req_l=0, addr 0x10, data 0xDEADBEEF -> next cycle mem_wr_en_l=0, mem_wr_addr=0x10, mem_wr_data=0xDEADBEEF, wr_ack_l=0, one cycle only.
REQ-037 Single read, RD_LATENCY=2, mem_rd_data model returns 0xA5A5A5A5 for addr 0x20 -> mem_rd_en_l one cycle, rd_ack_l=0 three edges later, rd_resp_data=0xA5A5A5A5.
REQ-038 Contention after reset: both requests low together -> write granted first, read next; repeated contention alternates W,R,W,R over 8 grants.
REQ-039 Back-to-back writes to 0x0..0x3 with compliant handshake -> exactly 4 mem_wr_en_l pulses, one per 2 cycles, no duplicates.
REQ-040 Reset asserted in READ_WAIT -> no rd_ack_l pulse, all outputs at REQ-034 values next cycle, busy=0.
REQ-041 Assertion throughout: mem_wr_en_l and mem_rd_en_l never both 0; each ack exactly one cycle wide.
